boolean_propose_controller: RTL and testbench

BOOLEAN_PROPOSE_CONTROLLER -- requirements
Module: boolean_propose_controller

---
 rtl/boolean_propose_controller.sv | 138 +++++++++++++
 tb/tb_boolean_propose_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boolean_propose_controller.sv
// Propose/evaluate sequencer for a Boolean local-search datapath: flips one variable per
// iteration and commits the flip when the evaluator accepts it. Define
// BOOLEAN_PROPOSE_RANDOM_INDEX_EN to pick the variable index from an LFSR instead of round-robin.
module boolean_propose_controller #(
    parameter int          MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX = 2,
    parameter int          ITERATION_WIDTH                          = 16,
    parameter logic [15:0] LFSR_SEED                                = 16'hACE1
) (
    input  logic                                                  in_clock,
    input  logic                                                  in_reset_n,
    input  logic                                                  in_start,
    input  logic [ITERATION_WIDTH-1:0]                            in_num_iterations,
    input  logic [2**MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX-1:0] in_initial_assignment,
    output logic                                                  out_propose_enable,
    output logic [MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX-1:0]   out_variable_index,
    output logic [2**MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX-1:0] out_current_assignment,
    input  logic [2**MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX-1:0] in_new_assignment,
    output logic                                                  out_eval_valid,
    input  logic                                                  in_eval_ready,
    output logic [2**MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX-1:0] out_eval_assignment,
    input  logic                                                  in_eval_done,
    input  logic                                                  in_eval_accept,
    output logic                                                  out_busy,
    output logic                                                  out_done,
    output logic [ITERATION_WIDTH-1:0]                            out_accept_count
);

    localparam int IDX_W = MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX;
    localparam int N     = 2**IDX_W;

    // An all-zero seed would lock the LFSR at zero forever.
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROPOSE,
        S_CAPTURE,
        S_EVAL_REQ,
        S_EVAL_WAIT,
        S_DONE
    } state_t;

    state_t                     state, next_state;
    logic [N-1:0]               current, proposed;
    logic [ITERATION_WIDTH-1:0] iter_target, iter_count, accept_count;
    logic [IDX_W-1:0]           index;

    logic start_ok, eval_hit, last_iter, advance;

    assign start_ok  = (state == S_IDLE) && in_start;
    assign eval_hit  = (state == S_EVAL_WAIT) && in_eval_done;
    assign last_iter = (iter_count + ITERATION_WIDTH'(1)) == iter_target;
    assign advance   = eval_hit && !last_iter;

    // NOTE: state registers use non-blocking assignments and reset asynchronously, so every
    // flop samples pre-edge values and outputs clear the instant reset asserts.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) state <= S_IDLE;
        else             state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:      if (in_start)
                             next_state = (in_num_iterations == '0) ? S_DONE : S_PROPOSE;
            S_PROPOSE:   next_state = S_CAPTURE;
            S_CAPTURE:   next_state = S_EVAL_REQ;
            S_EVAL_REQ:  if (in_eval_ready) next_state = S_EVAL_WAIT;
            S_EVAL_WAIT: if (in_eval_done)
                             next_state = last_iter ? S_DONE : S_PROPOSE;
            S_DONE:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            current      <= '0;
            proposed     <= '0;
            iter_target  <= '0;
            iter_count   <= '0;
            accept_count <= '0;
        end else begin
            if (start_ok) begin
                current      <= in_initial_assignment;
                iter_target  <= in_num_iterations;
                iter_count   <= '0;
                accept_count <= '0;
            end
            if (state == S_CAPTURE) proposed <= in_new_assignment;
            if (eval_hit) begin
                iter_count <= iter_count + ITERATION_WIDTH'(1);
                if (in_eval_accept) begin
                    current      <= proposed;
                    accept_count <= accept_count + ITERATION_WIDTH'(1);
                end
            end
        end
    end

`ifdef BOOLEAN_PROPOSE_RANDOM_INDEX_EN
    // Fibonacci LFSR, taps 16,14,13,11; free-running across runs, reseeded only by reset.
    logic [15:0] lfsr;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n)  lfsr <= LFSR_SEED;
        else if (advance) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign index = lfsr[IDX_W-1:0];
`else
    logic [IDX_W-1:0] rr_index;

    // Width equals the index width, so N-1 wraps to 0 naturally.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n)   rr_index <= '0;
        else if (start_ok) rr_index <= '0;
        else if (advance)  rr_index <= rr_index + IDX_W'(1);
    end

    assign index = rr_index;
`endif

    assign out_propose_enable     = (state == S_PROPOSE);
    assign out_variable_index     = (state == S_PROPOSE) ? index : '0;
    assign out_current_assignment = current;
    assign out_eval_valid         = (state == S_EVAL_REQ);
    assign out_eval_assignment    = proposed;
    assign out_busy               = (state != S_IDLE);
    assign out_done               = (state == S_DONE);
    assign out_accept_count       = accept_count;

endmodule

// File: tb/tb_boolean_propose_controller.sv
// Directed bench for boolean_propose_controller with a one-bit-flip datapath model and a
// handshaking evaluator model; define BOOLEAN_PROPOSE_RANDOM_INDEX_EN to check LFSR indexing.
module tb_boolean_propose_controller;

    localparam int IW = 2;
    localparam int N  = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_start = 1'b0;
    logic [TW-1:0] in_num_iterations = '0;
    logic [N-1:0]  in_initial_assignment = '0;
    logic          out_propose_enable;
    logic [IW-1:0] out_variable_index;
    logic [N-1:0]  out_current_assignment;
    logic [N-1:0]  in_new_assignment;
    logic          out_eval_valid;
    logic          in_eval_ready = 1'b1;
    logic [N-1:0]  out_eval_assignment;
    logic          in_eval_done;
    logic          in_eval_accept = 1'b1;
    logic          out_busy;
    logic          out_done;
    logic [TW-1:0] out_accept_count;

    logic          ev_auto = 1'b1;
    logic          force_done = 1'b0;
    logic          auto_done;

    always #5 clk = ~clk;

    boolean_propose_controller #(
        .MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX(IW),
        .ITERATION_WIDTH(TW),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .in_clock              (clk),
        .in_reset_n            (rst_n),
        .in_start              (in_start),
        .in_num_iterations     (in_num_iterations),
        .in_initial_assignment (in_initial_assignment),
        .out_propose_enable    (out_propose_enable),
        .out_variable_index    (out_variable_index),
        .out_current_assignment(out_current_assignment),
        .in_new_assignment     (in_new_assignment),
        .out_eval_valid        (out_eval_valid),
        .in_eval_ready         (in_eval_ready),
        .out_eval_assignment   (out_eval_assignment),
        .in_eval_done          (in_eval_done),
        .in_eval_accept        (in_eval_accept),
        .out_busy              (out_busy),
        .out_done              (out_done),
        .out_accept_count      (out_accept_count)
    );

    // Propose datapath: flips the requested bit, result valid the cycle after the enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  in_new_assignment <= '0;
        else if (out_propose_enable) in_new_assignment <= out_current_assignment ^ (N'(1) << out_variable_index);
    end

    // Evaluator: answers one cycle after each handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) auto_done <= 1'b0;
        else        auto_done <= ev_auto && out_eval_valid && in_eval_ready;
    end
    assign in_eval_done = auto_done | force_done;

    logic [IW-1:0] idx_q[$];
    int            pulse_cnt = 0;
    int            hs_cnt    = 0;
    int            done_cnt  = 0;

    always @(negedge clk) begin
        if (out_propose_enable) begin
            idx_q.push_back(out_variable_index);
            pulse_cnt++;
        end
        if (out_eval_valid && in_eval_ready) hs_cnt++;
        if (out_done) done_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [TW-1:0] iters, input logic [N-1:0] init);
        @(posedge clk); #1;
        in_start              = 1'b1;
        in_num_iterations     = iters;
        in_initial_assignment = init;
        @(posedge clk); #1;
        in_start = 1'b0;
    endtask

    // Returns how many rising edges after the start-sampling edge out_done appeared.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (out_done !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check(tag, out_done, 1'b1);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat, base_q, base_p, base_h, base_d, k;
        logic [IW-1:0] exp_idx[8];
        logic [N-1:0]  exp_cur;
        logic [15:0]   s;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", out_busy, 0);
        check("rst_done", out_done, 0);
        check("rst_cur", out_current_assignment, 0);
        check("rst_acc", out_accept_count, 0);
        check("rst_pe", out_propose_enable, 0);
        check("rst_valid", out_eval_valid, 0);
        check("rst_eval_asg", out_eval_assignment, 0);
        check("rst_idx", out_variable_index, 0);
        rst_n = 1'b1;

        // Four iterations, always accept: indices 0..3 each flip a zero bit
        base_q = idx_q.size(); base_p = pulse_cnt;
        start_run(4, 4'b0000);
        wait_done("t1_done_seen", lat);
        check("t1_latency", lat, 16);
        check("t1_cur", out_current_assignment, 4'b1111);
        check("t1_acc", out_accept_count, 4);
        check("t1_pulses", pulse_cnt - base_p, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_idx%0d", i), idx_q[base_q + i], i);
        @(posedge clk); #1;
        check("t1_done_one_cycle", out_done, 0);
        check("t1_idle", out_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_hold_cur", out_current_assignment, 4'b1111);
        check("t1_hold_acc", out_accept_count, 4);

        // Zero iterations: straight to DONE, nothing proposed
        base_p = pulse_cnt;
        start_run(0, 4'b1010);
        wait_done("t2_done_seen", lat);
        check("t2_latency", lat, 0);
        check("t2_cur", out_current_assignment, 4'b1010);
        check("t2_acc", out_accept_count, 0);
        @(posedge clk); #1;
        check("t2_pulses", pulse_cnt - base_p, 0);

        // Always reject: assignment untouched, round-robin restarts at 0
        in_eval_accept = 1'b0;
        base_q = idx_q.size(); base_p = pulse_cnt;
        start_run(3, 4'b0110);
        wait_done("t3_done_seen", lat);
        check("t3_latency", lat, 12);
        check("t3_cur", out_current_assignment, 4'b0110);
        check("t3_acc", out_accept_count, 0);
        check("t3_pulses", pulse_cnt - base_p, 3);
        check("t3_idx0", idx_q[base_q], 0);
        check("t3_idx2", idx_q[base_q + 2], 2);
        in_eval_accept = 1'b1;

        // Evaluator stalls 5 cycles; stray start and done during the stall are ignored
        in_eval_ready = 1'b0;
        base_h = hs_cnt;
        start_run(1, 4'b0000);
        k = 0;
        while (out_eval_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t4_valid_seen", out_eval_valid, 1'b1);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("t4_valid_c%0d", j), out_eval_valid, 1'b1);
            check($sformatf("t4_asg_c%0d", j), out_eval_assignment, 4'b0001);
            in_start              = (j == 1);
            in_num_iterations     = 5;
            in_initial_assignment = 4'b1111;
            force_done            = (j == 2);
            @(posedge clk); #1;
        end
        in_start = 1'b0; force_done = 1'b0; in_eval_ready = 1'b1;
        wait_done("t4_done_seen", lat);
        check("t4_cur", out_current_assignment, 4'b0001);
        check("t4_acc", out_accept_count, 1);
        @(posedge clk); #1;
        check("t4_handshakes", hs_cnt - base_h, 1);
        check("t4_no_rerun", out_busy, 0);

        // Reset while waiting for the evaluator
        ev_auto = 1'b0;
        start_run(2, 4'b1000);
        k = 0;
        while (out_eval_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        base_d = done_cnt;
        check("t5_pre_busy", out_busy, 1);
        check("t5_pre_asg", out_eval_assignment, 4'b1001);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", out_busy, 0);
        check("t5_rst_cur", out_current_assignment, 0);
        check("t5_rst_asg", out_eval_assignment, 0);
        check("t5_rst_valid", out_eval_valid, 0);
        check("t5_rst_acc", out_accept_count, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1; ev_auto = 1'b1;
        check("t5_no_done", done_cnt - base_d, 0);
        base_q = idx_q.size();
        start_run(1, 4'b0100);
        wait_done("t5_restart_done", lat);
        check("t5_restart_lat", lat, 4);
        check("t5_restart_cur", out_current_assignment, 4'b0101);
        check("t5_restart_acc", out_accept_count, 1);
        check("t5_restart_idx", idx_q[base_q], 0);

        // Eight iterations from a fresh reset; extra start during the run is ignored
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
`ifdef BOOLEAN_PROPOSE_RANDOM_INDEX_EN
        s = 16'hACE1;
        for (int i = 0; i < 8; i++) begin
            exp_idx[i] = s[IW-1:0];
            s = lfsr_next(s);
        end
`else
        s = 16'h0000;
        for (int i = 0; i < 8; i++) exp_idx[i] = IW'(i);
`endif
        exp_cur = 4'b0011;
        for (int i = 0; i < 8; i++) exp_cur = exp_cur ^ (N'(1) << exp_idx[i]);
        base_q = idx_q.size();
        start_run(8, 4'b0011);
        @(posedge clk); #1;
        in_start = 1'b1; in_num_iterations = 1; in_initial_assignment = 4'b0000;
        @(posedge clk); #1;
        in_start = 1'b0;
        wait_done("t6_done_seen", lat);
        check("t6_latency", lat + 2, 32);
        check("t6_cur", out_current_assignment, exp_cur);
        check("t6_acc", out_accept_count, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t6_idx%0d", i), idx_q[base_q + i], exp_idx[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
